// File: rtl/board_pkg.sv
// board_pkg
// Shared definitions for the parametrised N x N board controller:
//   - state_t     : controller FSM states (P1, P2, CHECK, DONE)
//   - PLAYER1/2   : encoding of the player who placed the most recent stone
//   - idx_w(n)    : width of a row-major cell index for an n x n board
package board_pkg;

  typedef enum logic [1:0] {
    P1    = 2'd0,
    P2    = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic PLAYER1 = 1'b0;
  localparam logic PLAYER2 = 1'b1;

  function automatic int idx_w(input int n);
    return $clog2(n * n);
  endfunction

endpackage

// File: rtl/kline_detect.sv
// kline_detect
// Combinational K-in-a-row detector for one player's N x N occupancy mask.
// Ports:
//   mask  in  N*N : occupancy mask, bit (row*N + col) is one cell
//   win   out 1   : some horizontal, vertical, diagonal or anti-diagonal
//                   window of K consecutive cells is fully occupied
module kline_detect
  import board_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic [N*N-1:0] mask,
  output logic           win
);

  // Number of window start positions along one line.
  localparam int SPAN = N - K + 1;

  logic [N*SPAN-1:0]    horiz;
  logic [N*SPAN-1:0]    vert;
  logic [SPAN*SPAN-1:0] diag;
  logic [SPAN*SPAN-1:0] anti;

  // Row windows start at (r, c); column windows reuse the same loop with the
  // roles swapped, so they start at (c, r) and run downwards.
  for (genvar r = 0; r < N; r++) begin : g_line
    for (genvar c = 0; c < SPAN; c++) begin : g_start
      logic [K-1:0] h_run;
      logic [K-1:0] v_run;
      for (genvar k = 0; k < K; k++) begin : g_cell
        assign h_run[k] = mask[r*N + c + k];
        assign v_run[k] = mask[(c + k)*N + r];
      end
      assign horiz[r*SPAN + c] = &h_run;
      assign vert[r*SPAN + c]  = &v_run;
    end
  end

  // Diagonal windows run down-right from (r, c); anti-diagonal windows run
  // down-left starting from (r, c+K-1), so both share the same start grid.
  for (genvar r = 0; r < SPAN; r++) begin : g_drow
    for (genvar c = 0; c < SPAN; c++) begin : g_dcol
      logic [K-1:0] d_run;
      logic [K-1:0] a_run;
      for (genvar k = 0; k < K; k++) begin : g_cell
        assign d_run[k] = mask[(r + k)*N + c + k];
        assign a_run[k] = mask[(r + k)*N + c + K - 1 - k];
      end
      assign diag[r*SPAN + c] = &d_run;
      assign anti[r*SPAN + c] = &a_run;
    end
  end

  assign win = |{horiz, vert, diag, anti};

endmodule

// File: rtl/board_ctrl_nk.sv
// board_ctrl_nk
// Two-player N x N board controller with K-in-a-row win detection, tie
// detection and arbitration between a human move source and an AI client.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   new_game            : one-cycle pulse, clears the board (highest priority)
//   game_mode           : 0 = two humans, 1 = player 2 is AI (latched on empty board)
//   move_valid/move_idx : human move offer; move_ready says it can be taken
//   ai_req              : AI turn pending; ai_valid/ai_idx is the AI move offer
//   cell_p1, cell_p2    : per-player occupancy masks, bit i is cell i
//   p1_turn, p2_turn    : whose move is awaited
//   p1_win, p2_win, tie : sticky outcome flags
//   illegal             : one-cycle pulse after a rejected move
//   moves               : number of stones on the board
module board_ctrl_nk
  import board_pkg::*;
#(
  parameter int N  = 3,
  parameter int K  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          new_game,
  input  logic          game_mode,
  input  logic          move_valid,
  input  logic [IW-1:0] move_idx,
  output logic          move_ready,
  output logic          ai_req,
  input  logic          ai_valid,
  input  logic [IW-1:0] ai_idx,
  output logic [N*N-1:0] cell_p1,
  output logic [N*N-1:0] cell_p2,
  output logic          p1_turn,
  output logic          p2_turn,
  output logic          p1_win,
  output logic          p2_win,
  output logic          tie,
  output logic          illegal,
  output logic [IW:0]   moves
);

  localparam int CELLS = N * N;
  localparam int EXT   = 2 ** IW;
  localparam logic [IW:0] CELLS_W = (IW + 1)'(CELLS);

  state_t           state;
  logic             mode;
  logic             mover;
  logic             offer;
  logic             legal;
  logic             win;
  logic [IW-1:0]    idx;
  logic [EXT-1:0]   occ_ext;
  logic [CELLS-1:0] sel;
  logic [CELLS-1:0] check_mask;

  // move_ready and ai_req are registered and already encode whose source is
  // allowed to move, so the handshake and the index mux only need them.
  // The occupancy vector is widened to the full index range so that an
  // out-of-range index can be looked up safely; the range test rejects it.
  always_comb begin
    offer      = (move_ready && move_valid) || (ai_req && ai_valid);
    idx        = ai_req ? ai_idx : move_idx;
    occ_ext    = '0;
    occ_ext[CELLS-1:0] = cell_p1 | cell_p2;
    sel        = CELLS'(1) << idx;
    legal      = ({1'b0, idx} < CELLS_W) && !occ_ext[idx];
    check_mask = (mover == PLAYER2) ? cell_p2 : cell_p1;
  end

  kline_detect #(
    .N(N),
    .K(K)
  ) u_kline (
    .mask(check_mask),
    .win (win)
  );

  // Game FSM. Turn flags, move_ready and ai_req are registered together with
  // the state they describe. The mode latch keeps tracking game_mode while the
  // board is empty in P1 and freezes once the first stone is down.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= P1;
      mode       <= 1'b0;
      mover      <= PLAYER1;
      cell_p1    <= '0;
      cell_p2    <= '0;
      moves      <= '0;
      move_ready <= 1'b1;
      ai_req     <= 1'b0;
      p1_turn    <= 1'b1;
      p2_turn    <= 1'b0;
      p1_win     <= 1'b0;
      p2_win     <= 1'b0;
      tie        <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      if (state == P1 && moves == '0) begin
        mode <= game_mode;
      end
      illegal <= 1'b0;

      if (new_game) begin
        state      <= P1;
        mover      <= PLAYER1;
        cell_p1    <= '0;
        cell_p2    <= '0;
        moves      <= '0;
        move_ready <= 1'b1;
        ai_req     <= 1'b0;
        p1_turn    <= 1'b1;
        p2_turn    <= 1'b0;
        p1_win     <= 1'b0;
        p2_win     <= 1'b0;
        tie        <= 1'b0;
      end else begin
        case (state)
          P1, P2: begin
            if (offer) begin
              if (legal) begin
                if (state == P1) begin
                  cell_p1 <= cell_p1 | sel;
                  mover   <= PLAYER1;
                end else begin
                  cell_p2 <= cell_p2 | sel;
                  mover   <= PLAYER2;
                end
                moves      <= moves + 1'b1;
                state      <= CHECK;
                move_ready <= 1'b0;
                ai_req     <= 1'b0;
                p1_turn    <= 1'b0;
                p2_turn    <= 1'b0;
              end else begin
                illegal <= 1'b1;
              end
            end
          end

          // Only the mover's mask is examined, so only the mover can win.
          CHECK: begin
            if (win) begin
              state <= DONE;
              if (mover == PLAYER1) begin
                p1_win <= 1'b1;
              end else begin
                p2_win <= 1'b1;
              end
            end else if (moves == CELLS_W) begin
              state <= DONE;
              tie   <= 1'b1;
            end else if (mover == PLAYER1) begin
              state      <= P2;
              p2_turn    <= 1'b1;
              move_ready <= !mode;
              ai_req     <= mode;
            end else begin
              state      <= P1;
              p1_turn    <= 1'b1;
              move_ready <= 1'b1;
            end
          end

          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_board_ctrl_nk.sv
// tb_board_ctrl_nk
// Self-checking bench for board_ctrl_nk. Two instances are exercised, a 3x3
// board with K=3 and a 5x5 board with K=4, one at a time through a shared
// driver. Expected behaviour comes from a move-level model of the game rules
// (board array, whose turn it is, line scan for wins) rather than a cycle model.
module tb_board_ctrl_nk;

  logic clk;
  logic reset;
  logic new_game;
  logic game_mode;

  logic        a_move_valid, a_ai_valid;
  logic [3:0]  a_move_idx, a_ai_idx;
  logic        a_move_ready, a_ai_req;
  logic [8:0]  a_cell_p1, a_cell_p2;
  logic        a_p1_turn, a_p2_turn, a_p1_win, a_p2_win, a_tie, a_illegal;
  logic [4:0]  a_moves;

  logic        b_move_valid, b_ai_valid;
  logic [4:0]  b_move_idx, b_ai_idx;
  logic        b_move_ready, b_ai_req;
  logic [24:0] b_cell_p1, b_cell_p2;
  logic        b_p1_turn, b_p2_turn, b_p1_win, b_p2_win, b_tie, b_illegal;
  logic [5:0]  b_moves;

  board_ctrl_nk #(.N(3), .K(3)) dut_a (
    .clk(clk), .reset(reset), .new_game(new_game), .game_mode(game_mode),
    .move_valid(a_move_valid), .move_idx(a_move_idx), .move_ready(a_move_ready),
    .ai_req(a_ai_req), .ai_valid(a_ai_valid), .ai_idx(a_ai_idx),
    .cell_p1(a_cell_p1), .cell_p2(a_cell_p2), .p1_turn(a_p1_turn), .p2_turn(a_p2_turn),
    .p1_win(a_p1_win), .p2_win(a_p2_win), .tie(a_tie), .illegal(a_illegal), .moves(a_moves)
  );

  board_ctrl_nk #(.N(5), .K(4)) dut_b (
    .clk(clk), .reset(reset), .new_game(new_game), .game_mode(game_mode),
    .move_valid(b_move_valid), .move_idx(b_move_idx), .move_ready(b_move_ready),
    .ai_req(b_ai_req), .ai_valid(b_ai_valid), .ai_idx(b_ai_idx),
    .cell_p1(b_cell_p1), .cell_p2(b_cell_p2), .p1_turn(b_p1_turn), .p2_turn(b_p2_turn),
    .p1_win(b_p1_win), .p2_win(b_p2_win), .tie(b_tie), .illegal(b_illegal), .moves(b_moves)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int sel = 0;

  // Outputs of whichever instance is currently selected.
  logic [63:0] o_cell_p1, o_cell_p2, o_moves;
  logic o_move_ready, o_ai_req, o_p1_turn, o_p2_turn, o_p1_win, o_p2_win, o_tie, o_illegal;

  always_comb begin
    if (sel == 0) begin
      o_cell_p1 = 64'(a_cell_p1); o_cell_p2 = 64'(a_cell_p2); o_moves = 64'(a_moves);
      o_move_ready = a_move_ready; o_ai_req = a_ai_req; o_p1_turn = a_p1_turn;
      o_p2_turn = a_p2_turn; o_p1_win = a_p1_win; o_p2_win = a_p2_win;
      o_tie = a_tie; o_illegal = a_illegal;
    end else begin
      o_cell_p1 = 64'(b_cell_p1); o_cell_p2 = 64'(b_cell_p2); o_moves = 64'(b_moves);
      o_move_ready = b_move_ready; o_ai_req = b_ai_req; o_p1_turn = b_p1_turn;
      o_p2_turn = b_p2_turn; o_p1_win = b_p1_win; o_p2_win = b_p2_win;
      o_tie = b_tie; o_illegal = b_illegal;
    end
  end

  // Reference model: board[i] is 0 (empty), 1 or 2.
  int board[64];
  int m_n = 3, m_k = 3, m_cur = 1, m_moves = 0, m_mode = 0;
  bit m_p1w = 0, m_p2w = 0, m_tie = 0, m_done = 0;

  task automatic model_clear();
    for (int i = 0; i < 64; i++) board[i] = 0;
    m_cur = 1; m_moves = 0; m_p1w = 0; m_p2w = 0; m_tie = 0; m_done = 0;
  endtask

  function automatic bit line_win(input int p);
    int dr[4] = '{0, 1, 1, 1};
    int dc[4] = '{1, 0, 1, -1};
    for (int r = 0; r < m_n; r++)
      for (int c = 0; c < m_n; c++)
        for (int d = 0; d < 4; d++) begin
          int cnt = 0;
          for (int j = 0; j < m_k; j++) begin
            int rr = r + dr[d] * j;
            int cc = c + dc[d] * j;
            if (rr >= 0 && rr < m_n && cc >= 0 && cc < m_n && board[rr*m_n + cc] == p) cnt++;
          end
          if (cnt == m_k) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expected);
    checks++;
    assert (obs === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expected);
    end
  endtask

  task automatic check_output(input string tag);
    logic [63:0] e1, e2;
    e1 = '0; e2 = '0;
    for (int i = 0; i < m_n * m_n; i++) begin
      if (board[i] == 1) e1[i] = 1'b1;
      if (board[i] == 2) e2[i] = 1'b1;
    end
    check({tag, ".cell_p1"}, o_cell_p1, e1);
    check({tag, ".cell_p2"}, o_cell_p2, e2);
    check({tag, ".moves"}, o_moves, 64'(m_moves));
    check({tag, ".p1_turn"}, 64'(o_p1_turn), 64'(!m_done && m_cur == 1));
    check({tag, ".p2_turn"}, 64'(o_p2_turn), 64'(!m_done && m_cur == 2));
    check({tag, ".move_ready"}, 64'(o_move_ready), 64'(!m_done && (m_cur == 1 || m_mode == 0)));
    check({tag, ".ai_req"}, 64'(o_ai_req), 64'(!m_done && m_cur == 2 && m_mode == 1));
    check({tag, ".p1_win"}, 64'(o_p1_win), 64'(m_p1w));
    check({tag, ".p2_win"}, 64'(o_p2_win), 64'(m_p2w));
    check({tag, ".tie"}, 64'(o_tie), 64'(m_tie));
  endtask

  task automatic drive(input bit human, input bit ai, input int idx);
    if (sel == 0) begin
      a_move_valid = human; a_ai_valid = ai; a_move_idx = 4'(idx); a_ai_idx = 4'(idx);
    end else begin
      b_move_valid = human; b_ai_valid = ai; b_move_idx = 5'(idx); b_ai_idx = 5'(idx);
    end
  endtask

  // One offer: present it for one edge, check the illegal pulse and early
  // mask/count update, then check the settled outcome one cycle later.
  // ng_check pulses new_game during the evaluation cycle.
  task automatic apply_stimulus(input bit human, input bit ai, input int idx,
                                input bit gm, input bit ng_check);
    bit exp_ill;
    bit accepted;
    bit ai_turn;
    exp_ill = 0; accepted = 0;
    @(negedge clk);
    game_mode = gm;
    drive(human, ai, idx);
    if (m_moves == 0) m_mode = gm;
    if (!m_done) begin
      ai_turn = (m_cur == 2 && m_mode == 1);
      if ((ai_turn && ai) || (!ai_turn && human)) begin
        if (idx < m_n * m_n && board[idx] == 0) begin
          board[idx] = m_cur;
          m_moves++;
          accepted = 1;
        end else begin
          exp_ill = 1;
        end
      end
    end
    @(negedge clk);
    drive(0, 0, 0);
    check("illegal_pulse", 64'(o_illegal), 64'(exp_ill));
    check("moves_early", o_moves, 64'(m_moves));
    if (ng_check) new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    if (ng_check) begin
      model_clear();
    end else if (accepted) begin
      if (line_win(m_cur)) begin
        if (m_cur == 1) m_p1w = 1; else m_p2w = 1;
        m_done = 1;
      end else if (m_moves == m_n * m_n) begin
        m_tie = 1; m_done = 1;
      end else begin
        m_cur = (m_cur == 1) ? 2 : 1;
      end
    end
    check("illegal_clear", 64'(o_illegal), 64'd0);
    check_output("settle");
  endtask

  // new_game pulse with a simultaneous move offer that must be dropped.
  task automatic new_game_pulse();
    @(negedge clk);
    new_game = 1'b1;
    drive(1, 1, $urandom_range(0, 8));
    @(negedge clk);
    new_game = 1'b0;
    drive(0, 0, 0);
    model_clear();
    check_output("new_game");
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    #1 reset = 1'b1;
    model_clear();
    m_mode = 0;
    #1 check_output("async_reset");
    check("async_reset.illegal", 64'(o_illegal), 64'd0);
    #1 reset = 1'b0;
  endtask

  task automatic random_game(input int steps);
    int free_q[$];
    int idx, idx_max;
    bit ai_turn, correct;
    idx_max = (sel == 0) ? 15 : 31;
    new_game_pulse();
    for (int s = 0; s < steps && !m_done; s++) begin
      free_q.delete();
      for (int i = 0; i < m_n * m_n; i++) if (board[i] == 0) free_q.push_back(i);
      if ($urandom_range(0, 9) < 7 && free_q.size() > 0)
        idx = free_q[$urandom_range(0, free_q.size() - 1)];
      else
        idx = $urandom_range(0, idx_max);
      ai_turn = (m_cur == 2 && m_mode == 1);
      correct = ($urandom_range(0, 9) < 8);
      if (ai_turn == correct) apply_stimulus(0, 1, idx, 1'($urandom_range(0, 1)), 0);
      else                    apply_stimulus(1, 0, idx, 1'($urandom_range(0, 1)), 0);
    end
  endtask

  initial begin
    reset = 1'b1; new_game = 1'b0; game_mode = 1'b0;
    a_move_valid = 0; a_ai_valid = 0; a_move_idx = '0; a_ai_idx = '0;
    b_move_valid = 0; b_ai_valid = 0; b_move_idx = '0; b_ai_idx = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check_output("reset");
    check("reset.illegal", 64'(o_illegal), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_output("post_reset");

    // Row win for P1 in two-human mode.
    $display("[TB] row win");
    apply_stimulus(1, 0, 0, 0, 0);
    apply_stimulus(1, 0, 3, 0, 0);
    apply_stimulus(1, 0, 1, 0, 0);
    apply_stimulus(1, 0, 4, 0, 0);
    apply_stimulus(1, 0, 2, 0, 0);
    check("row_win.p1_win", 64'(o_p1_win), 64'd1);
    check("row_win.moves", o_moves, 64'd5);
    apply_stimulus(1, 0, 8, 0, 0);

    // Full-board tie.
    $display("[TB] tie");
    new_game_pulse();
    foreach (board[i]) if (i < 0) board[i] = 0;
    apply_stimulus(1, 0, 0, 0, 0); apply_stimulus(1, 0, 1, 0, 0);
    apply_stimulus(1, 0, 2, 0, 0); apply_stimulus(1, 0, 4, 0, 0);
    apply_stimulus(1, 0, 3, 0, 0); apply_stimulus(1, 0, 5, 0, 0);
    apply_stimulus(1, 0, 7, 0, 0); apply_stimulus(1, 0, 6, 0, 0);
    apply_stimulus(1, 0, 8, 0, 0);
    check("tie.flag", 64'(o_tie), 64'd1);
    check("tie.moves", o_moves, 64'd9);

    // Illegal moves: occupied cell and out-of-range index.
    $display("[TB] illegal");
    new_game_pulse();
    apply_stimulus(0, 1, 5, 0, 0);
    apply_stimulus(1, 0, 4, 0, 0);
    apply_stimulus(1, 0, 4, 0, 0);
    apply_stimulus(1, 0, 9, 0, 0);
    check("illegal.cell_p2", o_cell_p2, 64'd0);
    check("illegal.p2_turn", 64'(o_p2_turn), 64'd1);

    // AI arbitration and mode latch.
    $display("[TB] ai mode");
    new_game_pulse();
    apply_stimulus(1, 0, 0, 1, 0);
    check("ai.req", 64'(o_ai_req), 64'd1);
    apply_stimulus(1, 0, 1, 1, 0);
    apply_stimulus(0, 1, 4, 1, 0);
    check("ai.cell_p2", o_cell_p2, 64'h10);
    apply_stimulus(1, 0, 2, 0, 0);
    check("latch.ai_req", 64'(o_ai_req), 64'd1);
    apply_stimulus(1, 0, 5, 0, 0);
    apply_stimulus(0, 1, 6, 0, 0);

    // new_game during CHECK discards a winning move.
    $display("[TB] abort paths");
    new_game_pulse();
    apply_stimulus(1, 0, 0, 0, 0); apply_stimulus(1, 0, 3, 0, 0);
    apply_stimulus(1, 0, 1, 0, 0); apply_stimulus(1, 0, 4, 0, 0);
    apply_stimulus(1, 0, 2, 0, 1);
    check("ng_check.p1_win", 64'(o_p1_win), 64'd0);
    apply_stimulus(1, 0, 7, 0, 0);
    apply_stimulus(1, 0, 8, 0, 0);
    async_reset_check();

    // Randomised games on the 3x3 board.
    $display("[TB] random 3x3");
    for (int g = 0; g < 8; g++) random_game(40);

    // 5x5 board, K=4: P2 anti-diagonal.
    $display("[TB] 5x5 anti-diagonal");
    sel = 1; m_n = 5; m_k = 4;
    new_game_pulse();
    apply_stimulus(1, 0, 0, 0, 0);  apply_stimulus(1, 0, 4, 0, 0);
    apply_stimulus(1, 0, 1, 0, 0);  apply_stimulus(1, 0, 8, 0, 0);
    apply_stimulus(1, 0, 3, 0, 0);  apply_stimulus(1, 0, 12, 0, 0);
    apply_stimulus(1, 0, 10, 0, 0); apply_stimulus(1, 0, 16, 0, 0);
    check("anti.p2_win", 64'(o_p2_win), 64'd1);
    for (int g = 0; g < 3; g++) random_game(80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
